alu_exec: RTL and testbench
===========================

// Module: alu_exec
// PURPOSE
//  Execute stage of DiBU. Consumes the two operands (a, b) read from the register bank.
//  Runs one ALU operation, either single-cycle or iterative (shift / shift-add multiply).
//  Returns the result as a single-cycle write request (wb_rw, wb_ri, wb_d).
//  That request drives the bank's rw, ri_d and d ports. Holds the Z/N/C status flags.
// PARAMETERS
//  WIDTH  8  data width of operands, result and bank data port
//  RIW    3  register index width (8 registers)
// PORTS
//  clk      in   1      main clock, all state changes on posedge
//  rst_n    in   1      asynchronous, active-low reset
//  start    in   1      request: op/a/b/ri_dst are valid this cycle
//  op       in   4      operation code, see BEHAVIOUR
//  a        in   WIDTH  operand A (bank output a)
//  b        in   WIDTH  operand B (bank output b)
//  ri_dst   in   RIW    destination register index
//  busy     out  1      high while an operation is in flight
//  done     out  1      one-cycle pulse when an operation completes
//  err      out  1      one-cycle pulse for an illegal op
//  wb_rw    out  1      write strobe to bank rw, one cycle per writing op
//  wb_ri    out  RIW    write index to bank ri_d
//  wb_d     out  WIDTH  write data to bank d
//  flag_z   out  1      zero flag
//  flag_n   out  1      negative flag (result MSB)
//  flag_c   out  1      carry / borrow / shifted-out flag
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; busy, done, err, wb_rw, wb_ri, wb_d and all flags = 0.
//   An operation in flight is aborted with no write-back; a new start is accepted on the 1st edge after release.
//  FSM states: IDLE, EXEC, WB.
//   IDLE -> start=1 latches op, a, b, ri_dst.
//    Single-cycle op, or shift with b[2:0]=0 -> WB. SHL/SHR with b[2:0]!=0, or MUL -> EXEC. Illegal op -> IDLE, err=1.
//   EXEC: one iteration per cycle; iteration counter reaches 0 -> WB.
//   WB (one cycle): done=1; wb_rw=1 (except CMP); flags updated -> IDLE.
//  busy = 1 in EXEC and WB, 0 in IDLE. start is ignored while busy.
//  Latency: start at edge N -> WB in the cycle after edge N+k.
//   k=1 for single-cycle ops; k=1+s for shifts by s=b[2:0]; k=9 for MUL.
//  wb_ri/wb_d hold their last values outside WB; only wb_rw qualifies them.
//  Ops (results truncated mod 2^WIDTH):
//   0 ADD a+b, C=carry out
//   1 SUB a-b, C=borrow (a<b)
//   2 AND, C=0
//   3 OR, C=0
//   4 XOR, C=0
//   5 NOT a, C=0
//   6 SHL a by b[2:0], 1 bit/cycle, C=last bit out (0 if s=0)
//   7 SHR logical, likewise
//   8 MUL a*b low byte, 8-cycle shift-add, C=(high byte!=0)
//   9 CMP: as SUB, flags only, no write
//   10 MOV b, C=0
//   11-15 illegal: err pulses for the cycle after the start edge; flags unchanged; no write
//  Z=(result==0), N=result[WIDTH-1], written only in WB. Flags persist between ops.
//  Upstream guarantees a/b are stable in the start cycle; they are not re-sampled afterwards.
// TESTING
//  ADD a=200,b=100,dst=3 -> next cycle wb_rw=1,wb_ri=3,wb_d=44,C=1,Z=0,N=0; busy 1 cycle
//  CMP a=3,b=7 -> done pulse, wb_rw stays 0, Z=0,N=1,C=1
//  SHL a=0x81,b=3 -> busy 4 cycles, wb_d=0x08,C=0; SHR a=0x81,b=0 -> 1 cycle, wb_d=0x81,C=0
//  MUL a=13,b=11 -> wb after 9 cycles, wb_d=143,C=0; MUL 16*16 -> wb_d=0,Z=1,C=1
//  start pulsed mid-MUL -> ignored, single write-back; rst_n low mid-MUL -> no wb_rw, all outputs 0
//  op=15 -> err pulse 1 cycle, busy=0, flags unchanged, no wb_rw; back-to-back ADDs every 2 cycles OK

Source files
------------

// File: rtl/alu_exec_if.sv
// alu_exec_if: the request and write-back bundle of the DiBU execute stage.
//   Request (master -> slave): start, op, a, b, ri_dst.
//   Response (slave -> master): busy, done, err, wb_rw/wb_ri/wb_d (bank write
//   port), flag_z/flag_n/flag_c (status flags).
interface alu_exec_if #(
  parameter int WIDTH = 8,
  parameter int RIW   = 3
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [RIW-1:0]   ri_dst;
  logic             busy;
  logic             done;
  logic             err;
  logic             wb_rw;
  logic [RIW-1:0]   wb_ri;
  logic [WIDTH-1:0] wb_d;
  logic             flag_z;
  logic             flag_n;
  logic             flag_c;

  modport master (
    output start, op, a, b, ri_dst,
    input  busy, done, err, wb_rw, wb_ri, wb_d, flag_z, flag_n, flag_c
  );

  modport slave (
    input  start, op, a, b, ri_dst,
    output busy, done, err, wb_rw, wb_ri, wb_d, flag_z, flag_n, flag_c
  );
endinterface

// File: rtl/alu_exec.sv
// alu_exec: execute stage of DiBU. Runs one ALU op per request, either in a
// single cycle or iteratively (shifts one bit per cycle, 8-step shift-add
// multiply), and returns a one-cycle register-bank write request.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : alu_exec_if.slave (request in, write-back and flags out)
//
// state | meaning
// IDLE  | waiting for start; illegal ops pulse err from here
// EXEC  | one shift / multiply iteration per cycle, cnt counts down
// WB    | done pulse, write strobe (not for CMP), flags just updated
module alu_exec #(
  parameter int WIDTH = 8,
  parameter int RIW   = 3
) (
  input logic       clk,
  input logic       rst_n,
  alu_exec_if.slave bus
);
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2,
                         OP_OR  = 4'd3, OP_XOR = 4'd4, OP_NOT = 4'd5,
                         OP_SHL = 4'd6, OP_SHR = 4'd7, OP_MUL = 4'd8,
                         OP_CMP = 4'd9, OP_MOV = 4'd10;

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t           state, state_d;
  logic [3:0]       op_q;
  logic [RIW-1:0]   ri_q;
  logic [WIDTH-1:0] hi, hi_d, lo, lo_d, mcand;
  logic             cbit, cbit_d;
  logic [3:0]       cnt, cnt_d;
  logic             latch, load, wr, wr_q, err_d;
  logic [WIDTH-1:0] res;
  logic             res_c;
  logic [WIDTH:0]   sum;
  logic [RIW-1:0]   ri_sel;
  logic [WIDTH-1:0] wb_d_q;
  logic [RIW-1:0]   wb_ri_q;
  logic             fz, fn, fc, err_q;

  always_comb begin
    state_d = state;
    latch   = 1'b0;
    load    = 1'b0;
    wr      = 1'b0;
    err_d   = 1'b0;
    res     = '0;
    res_c   = 1'b0;
    sum     = '0;
    hi_d    = hi;
    lo_d    = lo;
    cbit_d  = cbit;
    cnt_d   = cnt;
    ri_sel  = ri_q;
    case (state)
      IDLE: begin
        ri_sel = bus.ri_dst;
        if (bus.start) begin
          load    = 1'b1;
          wr      = 1'b1;
          state_d = WB;
          case (bus.op)
            OP_ADD: begin
              sum   = {1'b0, bus.a} + {1'b0, bus.b};
              res   = sum[WIDTH-1:0];
              res_c = sum[WIDTH];
            end
            OP_SUB, OP_CMP: begin
              // Borrow shows up as the extra top bit of the widened difference.
              sum   = {1'b0, bus.a} - {1'b0, bus.b};
              res   = sum[WIDTH-1:0];
              res_c = sum[WIDTH];
              wr    = (bus.op == OP_SUB);
            end
            OP_AND: res = bus.a & bus.b;
            OP_OR:  res = bus.a | bus.b;
            OP_XOR: res = bus.a ^ bus.b;
            OP_NOT: res = ~bus.a;
            OP_MOV: res = bus.b;
            OP_SHL, OP_SHR: begin
              if (bus.b[2:0] == 3'd0) begin
                res = bus.a;
              end else begin
                load    = 1'b0;
                wr      = 1'b0;
                latch   = 1'b1;
                lo_d    = bus.a;
                cbit_d  = 1'b0;
                cnt_d   = {1'b0, bus.b[2:0]};
                state_d = EXEC;
              end
            end
            OP_MUL: begin
              load    = 1'b0;
              wr      = 1'b0;
              latch   = 1'b1;
              hi_d    = '0;
              lo_d    = bus.b;
              cnt_d   = 4'd8;
              state_d = EXEC;
            end
            default: begin
              load    = 1'b0;
              wr      = 1'b0;
              err_d   = 1'b1;
              state_d = IDLE;
            end
          endcase
        end
      end
      EXEC: begin
        case (op_q)
          OP_SHL: begin
            cbit_d = lo[WIDTH-1];
            lo_d   = {lo[WIDTH-2:0], 1'b0};
          end
          OP_SHR: begin
            cbit_d = lo[0];
            lo_d   = {1'b0, lo[WIDTH-1:1]};
          end
          default: begin
            // Right-shifting multiplier: {hi,lo} ends up holding the product,
            // the multiplier bits drain out of lo as product bits fill it.
            sum  = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
            hi_d = sum[WIDTH:1];
            lo_d = {sum[0], lo[WIDTH-1:1]};
          end
        endcase
        cnt_d = cnt - 4'd1;
        if (cnt == 4'd1) begin
          load    = 1'b1;
          wr      = 1'b1;
          res     = lo_d;
          res_c   = (op_q == OP_MUL) ? (hi_d != '0) : cbit_d;
          state_d = WB;
        end
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      op_q    <= '0;
      ri_q    <= '0;
      hi      <= '0;
      lo      <= '0;
      mcand   <= '0;
      cbit    <= 1'b0;
      cnt     <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      wb_d_q  <= '0;
      wb_ri_q <= '0;
      fz      <= 1'b0;
      fn      <= 1'b0;
      fc      <= 1'b0;
    end else begin
      state <= state_d;
      hi    <= hi_d;
      lo    <= lo_d;
      cbit  <= cbit_d;
      cnt   <= cnt_d;
      err_q <= err_d;
      if (latch) begin
        op_q  <= bus.op;
        ri_q  <= bus.ri_dst;
        mcand <= bus.a;
      end
      if (load) begin
        wr_q <= wr;
        fz   <= (res == '0);
        fn   <= res[WIDTH-1];
        fc   <= res_c;
        if (wr) begin
          wb_d_q  <= res;
          wb_ri_q <= ri_sel;
        end
      end
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = (state == WB);
  assign bus.wb_rw  = (state == WB) && wr_q;
  assign bus.err    = err_q;
  assign bus.wb_d   = wb_d_q;
  assign bus.wb_ri  = wb_ri_q;
  assign bus.flag_z = fz;
  assign bus.flag_n = fn;
  assign bus.flag_c = fc;
endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed self-checking bench for alu_exec.
module tb_alu_exec;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   lat, nwr, cnt_bad;

  alu_exec_if #(.WIDTH(8), .RIW(3)) bus ();
  alu_exec #(.WIDTH(8), .RIW(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request and wait (bounded) for done; returns cycles until done
  // (0 on timeout) and number of write strobes seen. inj>0 pulses an extra
  // start while the op is still in flight.
  task automatic run_op(input logic [3:0] o, input logic [7:0] va, input logic [7:0] vb,
                        input logic [2:0] d, input int inj, output int l, output int w);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.a = va; bus.b = vb; bus.ri_dst = d;
    @(negedge clk);
    bus.start = 1'b0;
    l = 0; w = 0;
    for (int i = 1; i <= 20; i++) begin
      if (bus.wb_rw) w++;
      if (bus.done) begin l = i; break; end
      if (i == inj) begin
        bus.start = 1'b1; bus.op = 4'd0; bus.a = 8'd1; bus.b = 8'd1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
  endtask

  function automatic logic [2:0] flags();
    return {bus.flag_z, bus.flag_n, bus.flag_c};
  endfunction

  initial begin
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.ri_dst = '0;
    #12;
    check("reset_outs", {bus.busy, bus.done, bus.err, bus.wb_rw, bus.wb_ri, bus.wb_d, flags()}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(4'd0, 8'd200, 8'd100, 3'd3, 0, lat, nwr);
    check("add_lat", lat, 1);
    check("add_wr", nwr, 1);
    check("add_ri", bus.wb_ri, 3);
    check("add_d", bus.wb_d, 44);
    check("add_znc", flags(), 3'b001);
    @(negedge clk);
    check("add_busy_off", bus.busy, 0);

    run_op(4'd9, 8'd3, 8'd7, 3'd5, 0, lat, nwr);
    check("cmp_lat", lat, 1);
    check("cmp_wr", {nwr[0], bus.wb_rw}, 0);
    check("cmp_d_hold", {bus.wb_ri, bus.wb_d}, {3'd3, 8'd44});
    check("cmp_znc", flags(), 3'b011);

    run_op(4'd6, 8'h81, 8'd3, 3'd1, 0, lat, nwr);
    check("shl_lat", lat, 4);
    check("shl_wr", nwr, 1);
    check("shl_d", {bus.wb_ri, bus.wb_d}, {3'd1, 8'h08});
    check("shl_znc", flags(), 3'b000);

    run_op(4'd7, 8'h81, 8'd0, 3'd2, 0, lat, nwr);
    check("shr0_lat", lat, 1);
    check("shr0_d", bus.wb_d, 8'h81);
    check("shr0_znc", flags(), 3'b010);

    run_op(4'd7, 8'h81, 8'd1, 3'd2, 0, lat, nwr);
    check("shr1_lat", lat, 2);
    check("shr1_d", bus.wb_d, 8'h40);
    check("shr1_znc", flags(), 3'b001);

    run_op(4'd8, 8'd13, 8'd11, 3'd4, 0, lat, nwr);
    check("mul_lat", lat, 9);
    check("mul_wr", nwr, 1);
    check("mul_d", {bus.wb_ri, bus.wb_d}, {3'd4, 8'd143});
    check("mul_znc", flags(), 3'b010);

    run_op(4'd8, 8'd16, 8'd16, 3'd6, 0, lat, nwr);
    check("mul256_lat", lat, 9);
    check("mul256_d", bus.wb_d, 0);
    check("mul256_znc", flags(), 3'b101);

    run_op(4'd1, 8'd5, 8'd9, 3'd7, 0, lat, nwr);
    check("sub_d", {nwr[0], bus.wb_d}, {1'b1, 8'd252});
    check("sub_znc", flags(), 3'b011);

    run_op(4'd5, 8'h0F, 8'h00, 3'd0, 0, lat, nwr);
    check("not_d", bus.wb_d, 8'hF0);
    check("not_znc", flags(), 3'b010);

    run_op(4'd4, 8'hAA, 8'h0F, 3'd0, 0, lat, nwr);
    check("xor_d", bus.wb_d, 8'hA5);

    run_op(4'd10, 8'h55, 8'h00, 3'd1, 0, lat, nwr);
    check("mov_d", bus.wb_d, 8'h00);
    check("mov_znc", flags(), 3'b100);

    // Illegal op: err pulse only, flags stay at MOV's 100.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 4'd15; bus.a = 8'd1; bus.b = 8'd1; bus.ri_dst = 3'd2;
    @(negedge clk);
    bus.start = 1'b0;
    check("ill_err", {bus.err, bus.busy, bus.wb_rw, bus.done}, 4'b1000);
    check("ill_znc", flags(), 3'b100);
    @(negedge clk);
    check("ill_err_off", {bus.err, bus.busy, bus.wb_rw}, 3'b000);

    run_op(4'd8, 8'd13, 8'd11, 3'd7, 3, lat, nwr);
    check("mid_lat", lat, 9);
    check("mid_wr", nwr, 1);
    check("mid_d", {bus.wb_ri, bus.wb_d}, {3'd7, 8'd143});
    cnt_bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.busy || bus.wb_rw) cnt_bad++;
    end
    check("mid_no_extra", cnt_bad, 0);

    run_op(4'd0, 8'd1, 8'd2, 3'd0, 0, lat, nwr);
    check("b2b1", {lat[3:0], bus.wb_d}, {4'd1, 8'd3});
    run_op(4'd0, 8'h80, 8'h80, 3'd1, 0, lat, nwr);
    check("b2b2", {lat[3:0], bus.wb_ri, bus.wb_d}, {4'd1, 3'd1, 8'd0});
    check("b2b2_znc", flags(), 3'b101);

    @(negedge clk);
    bus.start = 1'b1; bus.op = 4'd8; bus.a = 8'd3; bus.b = 8'd3; bus.ri_dst = 3'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_outs", {bus.busy, bus.done, bus.err, bus.wb_rw, bus.wb_ri, bus.wb_d, flags()}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt_bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.busy || bus.wb_rw || bus.done) cnt_bad++;
    end
    check("rst_no_wb", cnt_bad, 0);
    run_op(4'd0, 8'd7, 8'd8, 3'd2, 0, lat, nwr);
    check("post_rst_add", {lat[3:0], nwr[3:0], bus.wb_d}, {4'd1, 4'd1, 8'd15});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
